// File: rtl/pb_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
package pb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} pb_state_t;

  localparam int unsigned PB_CNT_W_DEF = 20;

  // Debounced level is asserted while the button is considered held.
  function automatic logic is_pressed(input pb_state_t st);
    return (st == PRESSED) || (st == WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is a parameter.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: synchronizer, debounce FSM, press pulse and sticky event flag.
// Optional press counter output is built when PB_COUNT_EN is defined.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = PB_CNT_W_DEF,
  parameter bit          PB_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pb_raw,
  input  logic       clr_evt,
  output logic       pb_level,
  output logic       pb_press,
  output logic       pb_evt
`ifdef PB_COUNT_EN
  ,
  output logic [7:0] pb_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync2;
  logic s;

  // Flops reset to the released pin level so reset never looks like a press.
  sync_2ff #(
    .RESET_VAL(PB_ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pb_raw),
    .q    (sync2)
  );

  assign s = PB_ACTIVE_LOW ? ~sync2 : sync2;

  pb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             evt_q, evt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!s)                    state_d = IDLE;
        else if (cnt_q == CNT_MAX) state_d = PRESSED;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!s) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (s)                     state_d = PRESSED;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Any reversion discards partial qualification.
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so pb_level lands on the qualifying edge.
  always_comb begin
    level_d = is_pressed(state_d);
    press_d = (state_q == WAIT_PRESS) && (state_d == PRESSED);
    evt_d   = press_q | (evt_q & ~clr_evt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      evt_q   <= evt_d;
    end
  end

  assign pb_level = level_q;
  assign pb_press = press_q;
  assign pb_evt   = evt_q;

`ifdef PB_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)        count_q <= '0;
    else if (press_q) count_q <= count_q + 8'd1;
  end

  assign pb_count = count_q;
`endif

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner (DEBOUNCE_CYCLES=4, active-low pin) against a run-length reference model.
// Define PB_COUNT_EN to also exercise the press counter.
module tb_pb_conditioner;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic clk = 1'b0;
  logic reset, pb_raw, clr_evt;
  logic pb_level, pb_press, pb_evt;
`ifdef PB_COUNT_EN
  logic [7:0] pb_count;
`endif

  pb_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .PB_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pb_raw  (pb_raw),
    .clr_evt (clr_evt),
    .pb_level(pb_level),
    .pb_press(pb_press),
    .pb_evt  (pb_evt)
`ifdef PB_COUNT_EN
    ,
    .pb_count(pb_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Reference model: the pin reaches the debouncer two edges late; the level flips once
  // the delayed input has disagreed with it on D+1 consecutive edges.
  logic       raw_hist [2];
  logic       m_level, m_press, m_evt;
  logic [7:0] m_count;
  int         run;

  task automatic model_edge(input logic raw, input logic clr, input logic rst);
    logic s;
    if (rst) begin
      raw_hist[0] = 1'b1;
      raw_hist[1] = 1'b1;
      m_level = 1'b0;
      m_press = 1'b0;
      m_evt   = 1'b0;
      m_count = 8'd0;
      run     = 0;
    end else begin
      s = ~raw_hist[1];
      raw_hist[1] = raw_hist[0];
      raw_hist[0] = raw;
      m_evt   = m_press ? 1'b1 : (clr ? 1'b0 : m_evt);
      m_count = m_count + {7'd0, m_press};
      m_press = 1'b0;
      if (s != m_level) begin
        run++;
        if (run == D + 1) begin
          m_press = ~m_level;
          m_level = s;
          run     = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic step(input logic raw, input logic clr, input logic rst);
    pb_raw  = raw;
    clr_evt = clr;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, clr, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      vectors++;
      if ({pb_level, pb_press, pb_evt} !== 3'b000) begin
        fails++;
        $display("FAIL reset: got lvl/prs/evt=%b%b%b want 000", pb_level, pb_press, pb_evt);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if ({pb_level, pb_press, pb_evt} !== {m_level, m_press, m_evt}) begin
        fails++;
        $display("FAIL reset_idle: got %b%b%b want %b%b%b", pb_level, pb_press, pb_evt,
                 m_level, m_press, m_evt);
      end
    end
  endtask

  task automatic test_clean_press();
    int lvl_edge = -1;
    int press_n  = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({pb_level, pb_press, pb_evt} !== {m_level, m_press, m_evt}) begin
        fails++;
        $display("FAIL clean_cycle%0d: got %b%b%b want %b%b%b", i, pb_level, pb_press, pb_evt,
                 m_level, m_press, m_evt);
      end
      if (pb_level && lvl_edge < 0) lvl_edge = i;
      if (pb_press) press_n++;
    end
    vectors++;
    if (lvl_edge != LAT) begin
      fails++;
      $display("FAIL clean_latency: got %0d edges want %0d", lvl_edge, LAT);
    end
    vectors++;
    if (press_n != 1) begin
      fails++;
      $display("FAIL clean_held_pulses: got %0d want 1", press_n);
    end
    vectors++;
    if (pb_evt !== 1'b1) begin
      fails++;
      $display("FAIL clean_evt: got %b want 1", pb_evt);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (pb_evt !== 1'b0) begin
      fails++;
      $display("FAIL clear_evt: got %b want 0", pb_evt);
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (pb_evt !== m_evt || pb_level !== 1'b1) begin
      fails++;
      $display("FAIL clear_hold: got evt=%b lvl=%b want evt=%b lvl=1", pb_evt, pb_level, m_evt);
    end
  endtask

  task automatic test_release();
    logic pat[17] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int   fall_edge = -1;
    int   press_n   = 0;
    for (int i = 0; i < 17; i++) begin
      step(pat[i], 1'b0, 1'b0);
      vectors++;
      if ({pb_level, pb_press, pb_evt} !== {m_level, m_press, m_evt}) begin
        fails++;
        $display("FAIL release_cycle%0d: got %b%b%b want %b%b%b", i, pb_level, pb_press,
                 pb_evt, m_level, m_press, m_evt);
      end
      if (!pb_level && fall_edge < 0) fall_edge = i - 2;
      if (pb_press) press_n++;
    end
    vectors++;
    if (fall_edge != LAT) begin
      fails++;
      $display("FAIL release_latency: got %0d edges want %0d", fall_edge, LAT);
    end
    vectors++;
    if (press_n != 0) begin
      fails++;
      $display("FAIL release_pulse: got %0d pulses want 0", press_n);
    end
  endtask

  task automatic test_bounce();
    logic pat[18] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int   press_edge = -1;
    int   press_n    = 0;
    for (int i = 0; i < 18; i++) begin
      step(pat[i], 1'b0, 1'b0);
      vectors++;
      if ({pb_level, pb_press, pb_evt} !== {m_level, m_press, m_evt}) begin
        fails++;
        $display("FAIL bounce_cycle%0d: got %b%b%b want %b%b%b", i, pb_level, pb_press,
                 pb_evt, m_level, m_press, m_evt);
      end
      if (pb_press) begin
        press_n++;
        if (press_edge < 0) press_edge = i - 3;
      end
    end
    vectors++;
    if (press_edge != LAT || press_n != 1) begin
      fails++;
      $display("FAIL bounce_pulse: got edge %0d count %0d want edge %0d count 1", press_edge,
               press_n, LAT);
    end
  endtask

  task automatic test_clear_coincident();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({pb_level, pb_evt} !== 2'b00) begin
      fails++;
      $display("FAIL coinc_setup: got lvl/evt=%b%b want 00", pb_level, pb_evt);
    end
    for (int i = 1; i <= LAT; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (pb_press !== 1'b1) begin
      fails++;
      $display("FAIL coinc_press: got %b want 1", pb_press);
    end
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (pb_evt !== 1'b1 || pb_evt !== m_evt) begin
      fails++;
      $display("FAIL coinc_set_wins: got %b want 1", pb_evt);
    end
  endtask

  task automatic test_reset_mid();
    int press_edge = -1;
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // Five edges after the fall the FSM sits in WAIT_PRESS with cnt=2.
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({pb_level, pb_press} !== 2'b00) begin
      fails++;
      $display("FAIL midreset_pre: got lvl/prs=%b%b want 00", pb_level, pb_press);
    end
    step(1'b0, 1'b0, 1'b1);
    vectors++;
    if ({pb_level, pb_press, pb_evt} !== 3'b000) begin
      fails++;
      $display("FAIL midreset_outputs: got %b%b%b want 000", pb_level, pb_press, pb_evt);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({pb_level, pb_press, pb_evt} !== {m_level, m_press, m_evt}) begin
        fails++;
        $display("FAIL midreset_cycle%0d: got %b%b%b want %b%b%b", i, pb_level, pb_press,
                 pb_evt, m_level, m_press, m_evt);
      end
      if (pb_press && press_edge < 0) press_edge = i;
    end
    vectors++;
    if (press_edge != LAT) begin
      fails++;
      $display("FAIL midreset_pulse_edge: got %0d want %0d", press_edge, LAT);
    end
  endtask

  task automatic test_random();
    logic raw;
    int   hold;
    for (int seg = 0; seg < 250; seg++) begin
      raw  = 1'($urandom_range(1, 0));
      hold = int'($urandom_range(12, 1));
      for (int i = 0; i < hold; i++) begin
        step(raw, ($urandom_range(7, 0) == 0), 1'b0);
        vectors++;
        if ({pb_level, pb_press, pb_evt} !== {m_level, m_press, m_evt}) begin
          fails++;
          $display("FAIL random_seg%0d: got %b%b%b want %b%b%b", seg, pb_level, pb_press,
                   pb_evt, m_level, m_press, m_evt);
        end
`ifdef PB_COUNT_EN
        vectors++;
        if (pb_count !== m_count) begin
          fails++;
          $display("FAIL random_count: got %0d want %0d", pb_count, m_count);
        end
`endif
      end
    end
  endtask

`ifdef PB_COUNT_EN
  task automatic test_count();
    step(1'b1, 1'b0, 1'b1);
    for (int p = 1; p <= 257; p++) begin
      for (int i = 0; i < 10; i++) step(1'b0, (i == 8), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      if (p == 256) begin
        vectors++;
        if (pb_count !== 8'd0) begin
          fails++;
          $display("FAIL count_wrap: got %0d want 0", pb_count);
        end
      end
    end
    vectors++;
    if (pb_count !== 8'd1 || pb_count !== m_count) begin
      fails++;
      $display("FAIL count_257: got %0d want 1", pb_count);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    vectors++;
    if (pb_count !== 8'd1) begin
      fails++;
      $display("FAIL count_clr: got %0d want 1", pb_count);
    end
  endtask
`endif

  initial begin
    pb_raw  = 1'b1;
    clr_evt = 1'b0;
    reset   = 1'b1;
    test_reset();
    test_clean_press();
    test_clear();
    test_release();
    test_bounce();
    test_clear_coincident();
    test_reset_mid();
    test_random();
`ifdef PB_COUNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
